// File: rtl/irig_time_pkg.sv
// Shared definitions for the UART time-set frame parser: frame geometry,
// parser state encoding, rejection codes, time field widths and range limits.
package irig_time_pkg;

   localparam int unsigned BYTE_W      = 8;
   localparam int unsigned FRAME_LEN   = 9;
   localparam int unsigned PAYLOAD_LEN = 6;
   localparam int unsigned IDX_W       = 3;

   localparam int unsigned SEC_W  = 6;
   localparam int unsigned MIN_W  = 6;
   localparam int unsigned HOUR_W = 5;
   localparam int unsigned DAY_W  = 9;
   localparam int unsigned YEAR_W = 7;
   localparam int unsigned ERR_W  = 2;

   localparam int unsigned SEC_MAX  = 59;
   localparam int unsigned MIN_MAX  = 59;
   localparam int unsigned HOUR_MAX = 23;
   localparam int unsigned DAY_MIN  = 1;
   localparam int unsigned DAY_MAX  = 366;
   localparam int unsigned YEAR_MAX = 99;

   localparam logic [ERR_W-1:0] ERR_NONE    = ERR_W'(0);
   localparam logic [ERR_W-1:0] ERR_CSUM    = ERR_W'(1);
   localparam logic [ERR_W-1:0] ERR_RANGE   = ERR_W'(2);
   localparam logic [ERR_W-1:0] ERR_TIMEOUT = ERR_W'(3);

   typedef enum logic [2:0] {
      ST_HUNT,
      ST_HDR1,
      ST_PAYLOAD,
      ST_CHKSUM,
      ST_VERIFY
   } parser_state_e;

   typedef struct packed {
      logic [YEAR_W-1:0] year;
      logic [DAY_W-1:0]  day;
      logic [HOUR_W-1:0] hour;
      logic [MIN_W-1:0]  min;
      logic [SEC_W-1:0]  sec;
   } irig_time_t;

   localparam irig_time_t TIME_RESET = '{year: '0, day: DAY_W'(DAY_MIN),
                                         hour: '0, min: '0, sec: '0};

   // Whole-byte range check; upper bits of any field byte count as out of range.
   function automatic logic fields_in_range(input logic [BYTE_W-1:0] sec,
                                            input logic [BYTE_W-1:0] min,
                                            input logic [BYTE_W-1:0] hour,
                                            input logic [BYTE_W-1:0] dayh,
                                            input logic [BYTE_W-1:0] dayl,
                                            input logic [BYTE_W-1:0] year);
      logic [DAY_W-1:0] day;
      day = {dayh[0], dayl};
      return (sec  <= BYTE_W'(SEC_MAX))  &&
             (min  <= BYTE_W'(MIN_MAX))  &&
             (hour <= BYTE_W'(HOUR_MAX)) &&
             (dayh[BYTE_W-1:1] == '0)    &&
             (day  >= DAY_W'(DAY_MIN))   &&
             (day  <= DAY_W'(DAY_MAX))   &&
             (year <= BYTE_W'(YEAR_MAX));
   endfunction

endpackage

// File: rtl/uart_time_frame_parser_if.sv
// Byte-stream input and time-vector output bundle of the time frame parser.
interface uart_time_frame_parser_if;
   import irig_time_pkg::*;

   logic [BYTE_W-1:0] rx_data;
   logic              rx_flag;
   logic [SEC_W-1:0]  time_sec;
   logic [MIN_W-1:0]  time_min;
   logic [HOUR_W-1:0] time_hour;
   logic [DAY_W-1:0]  time_day;
   logic [YEAR_W-1:0] time_year;
   logic              time_valid;
   logic              frame_err;
   logic [ERR_W-1:0]  err_code;

   modport master (
      output rx_data, rx_flag,
      input  time_sec, time_min, time_hour, time_day, time_year,
      input  time_valid, frame_err, err_code
   );

   modport slave (
      input  rx_data, rx_flag,
      output time_sec, time_min, time_hour, time_day, time_year,
      output time_valid, frame_err, err_code
   );

endinterface

// File: rtl/frame_timeout_timer.sv
// Inter-byte idle counter; expire_c pulses in the cycle the count sits at
// TIMEOUT_CYC-1 while enabled and not being cleared.
module frame_timeout_timer #(
   parameter int unsigned TIMEOUT_CYC = 2_500_000
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic clear_i,
   input  logic en_i,
   output logic expire_c
);

   localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign expire_c = en_i && !clear_i && (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) cnt_q <= '0;
      else            cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_time_frame_parser.sv
// Assembles 9-byte time-set frames from the UART byte stream, validates header,
// checksum and field ranges, and loads a registered time vector or flags an error.
module uart_time_frame_parser
   import irig_time_pkg::*;
#(
   parameter int unsigned CLK_FREQ    = 50_000_000,
   parameter int unsigned TIMEOUT_CYC = CLK_FREQ / 20,
   parameter logic [7:0]  HEADER0     = 8'hAA,
   parameter logic [7:0]  HEADER1     = 8'h55
) (
   input logic                 sys_clk,
   input logic                 sys_rst_n,
   uart_time_frame_parser_if.slave bus
);

   parser_state_e                        state_q, state_d;
   logic [IDX_W-1:0]                     idx_q, idx_d;
   logic [BYTE_W-1:0]                    sum_q, sum_d;
   logic [PAYLOAD_LEN-1:0][BYTE_W-1:0]   payload_q, payload_d;
   logic                                 csum_ok_q, csum_ok_d;
   irig_time_t                           time_q, time_d;
   logic                                 time_valid_q, time_valid_d;
   logic                                 frame_err_q, frame_err_d;
   logic [ERR_W-1:0]                     err_code_q, err_code_d;

   logic tmr_clear, tmr_en, tmr_expire_c;
   logic range_ok;

   assign tmr_clear = bus.rx_flag || (state_q == ST_HUNT);
   assign tmr_en    = (state_q == ST_HDR1) || (state_q == ST_PAYLOAD) ||
                      (state_q == ST_CHKSUM);

   frame_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .clear_i   (tmr_clear),
      .en_i      (tmr_en),
      .expire_c  (tmr_expire_c)
   );

   assign range_ok = fields_in_range(payload_q[0], payload_q[1], payload_q[2],
                                     payload_q[3], payload_q[4], payload_q[5]);

   // Parser next-state and output decode; a pending byte always beats the timeout.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      sum_d        = sum_q;
      payload_d    = payload_q;
      csum_ok_d    = csum_ok_q;
      time_d       = time_q;
      time_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      err_code_d   = err_code_q;

      unique case (state_q)
         ST_HUNT: begin
            if (bus.rx_flag && (bus.rx_data == HEADER0)) state_d = ST_HDR1;
         end
         ST_HDR1: begin
            if (bus.rx_flag) begin
               if (bus.rx_data == HEADER1) begin
                  state_d = ST_PAYLOAD;
                  idx_d   = '0;
                  sum_d   = '0;
               end else if (bus.rx_data != HEADER0) begin
                  state_d = ST_HUNT;
               end
            end else if (tmr_expire_c) begin
               state_d     = ST_HUNT;
               frame_err_d = 1'b1;
               err_code_d  = ERR_TIMEOUT;
            end
         end
         ST_PAYLOAD: begin
            if (bus.rx_flag) begin
               for (int i = 0; i < int'(PAYLOAD_LEN); i++) begin
                  if (idx_q == IDX_W'(i)) payload_d[i] = bus.rx_data;
               end
               sum_d = sum_q + bus.rx_data;
               if (idx_q == IDX_W'(PAYLOAD_LEN - 1)) state_d = ST_CHKSUM;
               else                                  idx_d   = idx_q + IDX_W'(1);
            end else if (tmr_expire_c) begin
               state_d     = ST_HUNT;
               frame_err_d = 1'b1;
               err_code_d  = ERR_TIMEOUT;
            end
         end
         ST_CHKSUM: begin
            if (bus.rx_flag) begin
               csum_ok_d = (bus.rx_data == sum_q);
               state_d   = ST_VERIFY;
            end else if (tmr_expire_c) begin
               state_d     = ST_HUNT;
               frame_err_d = 1'b1;
               err_code_d  = ERR_TIMEOUT;
            end
         end
         ST_VERIFY: begin
            state_d = ST_HUNT;
            if (!csum_ok_q) begin
               frame_err_d = 1'b1;
               err_code_d  = ERR_CSUM;
            end else if (!range_ok) begin
               frame_err_d = 1'b1;
               err_code_d  = ERR_RANGE;
            end else begin
               time_valid_d = 1'b1;
               time_d.sec   = payload_q[0][SEC_W-1:0];
               time_d.min   = payload_q[1][MIN_W-1:0];
               time_d.hour  = payload_q[2][HOUR_W-1:0];
               time_d.day   = {payload_q[3][0], payload_q[4]};
               time_d.year  = payload_q[5][YEAR_W-1:0];
            end
         end
         default: state_d = ST_HUNT;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= ST_HUNT;
         idx_q        <= '0;
         sum_q        <= '0;
         payload_q    <= '0;
         csum_ok_q    <= 1'b0;
         time_q       <= TIME_RESET;
         time_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         err_code_q   <= ERR_NONE;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         sum_q        <= sum_d;
         payload_q    <= payload_d;
         csum_ok_q    <= csum_ok_d;
         time_q       <= time_d;
         time_valid_q <= time_valid_d;
         frame_err_q  <= frame_err_d;
         err_code_q   <= err_code_d;
      end
   end

   assign bus.time_sec   = time_q.sec;
   assign bus.time_min   = time_q.min;
   assign bus.time_hour  = time_q.hour;
   assign bus.time_day   = time_q.day;
   assign bus.time_year  = time_q.year;
   assign bus.time_valid = time_valid_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.err_code   = err_code_q;

endmodule
